// File: rtl/mulseq_pkg.sv
// Shared constants, state encoding and register-index mapping for the
// LDM/STM/PUSH/POP sequencer.
package mulseq_pkg;

   localparam int          LIST_W     = 10;
   localparam logic [3:0]  REG_LR     = 4'd14;
   localparam logic [3:0]  REG_PC     = 4'd15;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WB   = 2'd2
   } state_t;

   // List bit 8 is LR and bit 9 is PC; bits 7:0 map straight to R0-R7.
   function automatic logic [3:0] bit_to_reg(input int b);
      if (b == 8)
         return REG_LR;
      else if (b == 9)
         return REG_PC;
      else
         return 4'(b);
   endfunction

endpackage

// File: rtl/list_lsb_enc.sv
// Lowest-set-bit encoder over the 10-bit register list: register index,
// one-hot clear mask and a flag for "exactly one bit left".
import mulseq_pkg::*;

module list_lsb_enc (
   input  logic [LIST_W-1:0] list,
   output logic [3:0]        reg_idx,
   output logic [LIST_W-1:0] clr_mask,
   output logic              last
);

   genvar gi;
   generate
      for (gi = 0; gi < LIST_W; gi++) begin : g_mask
         if (gi == 0) begin : g_first
            assign clr_mask[gi] = list[gi];
         end else begin : g_rest
            assign clr_mask[gi] = list[gi] & ~(|list[gi-1:0]);
         end
      end
   endgenerate

   always_comb begin
      reg_idx = 4'd0;
      for (int i = 0; i < LIST_W; i++) begin
         if (clr_mask[i])
            reg_idx = bit_to_reg(i);
      end
   end

   // A list equal to its own lowest one-hot has exactly one bit set.
   assign last = (list != '0) && (list == clr_mask);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Thumb multiple-register transfer sequencer (IDLE -> XFER -> WB).
// Define MULSEQ_WB_EN to generate the base-register writeback value.
import mulseq_pkg::*;

module ldm_stm_sequencer (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic              descending,
   input  logic [LIST_W-1:0] reg_list,
   input  logic [31:0]       base_addr,
   input  logic              ack,
   output logic              busy,
   output logic [LIST_W-1:0] list_left,
   output logic              beat_valid,
   output logic [3:0]        beat_reg,
   output logic [31:0]       beat_addr,
   output logic              beat_load,
   output logic              pc_load,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic              done
);

   state_t              state_q, state_d;
   logic [LIST_W-1:0]   list_q, list_d;
   logic [31:0]         addr_q, addr_d;
   logic                load_q, load_d;
   logic                zdone_q, zdone_d;

   logic [3:0]          pop;
   logic [31:0]         span;
   logic                launch;
   logic [3:0]          enc_reg;
   logic [LIST_W-1:0]   enc_clr;
   logic                enc_last;

   list_lsb_enc u_enc (
      .list     (list_q),
      .reg_idx  (enc_reg),
      .clr_mask (enc_clr),
      .last     (enc_last)
   );

   always_comb begin
      pop = 4'd0;
      for (int i = 0; i < LIST_W; i++)
         pop = pop + 4'(reg_list[i]);
   end

   assign span   = 32'(pop) * WORD_BYTES;
   assign launch = (state_q == IDLE) && start && (reg_list != '0);

   always_comb begin
      state_d = state_q;
      list_d  = list_q;
      addr_d  = addr_q;
      load_d  = load_q;
      zdone_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (launch) begin
               list_d  = reg_list;
               load_d  = is_load;
               // Beats always climb; a descending block just starts lower.
               addr_d  = descending ? (base_addr - span) : base_addr;
               state_d = XFER;
            end else if (start) begin
               zdone_d = 1'b1;
            end
         end
         XFER: begin
            if (ack) begin
               list_d = list_q & ~enc_clr;
               addr_d = addr_q + WORD_BYTES;
               if (enc_last)
                  state_d = WB;
            end
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         list_q  <= '0;
         addr_q  <= '0;
         load_q  <= 1'b0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         list_q  <= list_d;
         addr_q  <= addr_d;
         load_q  <= load_d;
         zdone_q <= zdone_d;
      end
   end

`ifdef MULSEQ_WB_EN
   logic [31:0] wb_q, wb_d;

   always_comb begin
      wb_d = wb_q;
      if (launch)
         wb_d = descending ? (base_addr - span) : (base_addr + span);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wb_q <= '0;
      else
         wb_q <= wb_d;
   end

   assign wb_valid = (state_q == WB);
   assign wb_data  = wb_q;
`else
   assign wb_valid = 1'b0;
   assign wb_data  = '0;
`endif

   assign busy       = (state_q != IDLE);
   assign list_left  = list_q;
   assign beat_valid = (state_q == XFER);
   assign beat_reg   = enc_reg;
   assign beat_addr  = beat_valid ? addr_q : '0;
   assign beat_load  = beat_valid & load_q;
   assign pc_load    = beat_valid & ack & load_q & (enc_reg == REG_PC);
   assign done       = (state_q == WB) | zdone_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed, table-driven bench for ldm_stm_sequencer plus hand-written
// sequences for stall, empty list and mid-transfer reset.
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic        descending = 1'b0;
   logic [9:0]  reg_list = '0;
   logic [31:0] base_addr = '0;
   logic        ack = 1'b0;
   logic        busy;
   logic [9:0]  list_left;
   logic        beat_valid;
   logic [3:0]  beat_reg;
   logic [31:0] beat_addr;
   logic        beat_load;
   logic        pc_load;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MULSEQ_WB_EN
   localparam bit WB_ON = 1'b1;
`else
   localparam bit WB_ON = 1'b0;
`endif

   typedef struct {
      logic [9:0]  lst;
      logic [31:0] base;
      logic        desc;
      logic        ld;
      int          n;
      logic [31:0] first_addr;
      logic [3:0]  last_reg;
      logic [31:0] wb;
   } vec_t;

   vec_t vecs[5];

   ldm_stm_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .is_load    (is_load),
      .descending (descending),
      .reg_list   (reg_list),
      .base_addr  (base_addr),
      .ack        (ack),
      .busy       (busy),
      .list_left  (list_left),
      .beat_valid (beat_valid),
      .beat_reg   (beat_reg),
      .beat_addr  (beat_addr),
      .beat_load  (beat_load),
      .pc_load    (pc_load),
      .wb_valid   (wb_valid),
      .wb_data    (wb_data),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] low_reg(input logic [9:0] l);
      for (int i = 0; i < 10; i++) begin
         if (l[i])
            return (i == 8) ? 4'd14 : (i == 9) ? 4'd15 : 4'(i);
      end
      return 4'd0;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, ".busy"},       32'(busy),       32'd0);
      chk({tag, ".list_left"},  32'(list_left),  32'd0);
      chk({tag, ".beat_valid"}, 32'(beat_valid), 32'd0);
      chk({tag, ".beat_reg"},   32'(beat_reg),   32'd0);
      chk({tag, ".beat_addr"},  beat_addr,       32'd0);
      chk({tag, ".beat_load"},  32'(beat_load),  32'd0);
      chk({tag, ".pc_load"},    32'(pc_load),    32'd0);
      chk({tag, ".wb_valid"},   32'(wb_valid),   32'd0);
      chk({tag, ".wb_data"},    wb_data,         32'd0);
      chk({tag, ".done"},       32'(done),       32'd0);
   endtask

   // ack held high: n beats, then WB with done, then idle.
   task automatic run_vec(input int idx, input vec_t v);
      logic [9:0] rem;
      logic [3:0] er;
      int bad0;
      bad0 = n_bad;
      @(negedge clk);
      reg_list = v.lst; base_addr = v.base; descending = v.desc;
      is_load = v.ld; ack = 1'b1; start = 1'b1;
      #1 chk("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0; reg_list = '0;
      rem = v.lst;
      for (int k = 0; k < v.n; k++) begin
         #1;
         er = low_reg(rem);
         chk("beat_valid", 32'(beat_valid), 32'd1);
         chk("beat_reg",   32'(beat_reg),   32'(er));
         chk("beat_addr",  beat_addr,       v.first_addr + 32'(k) * 32'd4);
         chk("list_left",  32'(list_left),  32'(rem));
         chk("beat_load",  32'(beat_load),  32'(v.ld));
         chk("pc_load",    32'(pc_load),    32'(v.ld && (er == 4'd15)));
         chk("busy_xfer",  32'(busy),       32'd1);
         if (k == v.n - 1)
            chk("last_reg", 32'(beat_reg), 32'(v.last_reg));
         rem = rem & (rem - 10'd1);
         @(negedge clk);
      end
      #1;
      chk("wb_done",       32'(done),       32'd1);
      chk("wb_busy",       32'(busy),       32'd1);
      chk("wb_beat_valid", 32'(beat_valid), 32'd0);
      chk("wb_valid",      32'(wb_valid),   32'(WB_ON));
      chk("wb_data",       wb_data,         WB_ON ? v.wb : 32'd0);
      @(negedge clk);
      #1;
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_done", 32'(done), 32'd0);
      ack = 1'b0;
      $display("txn %0d list=%03h base=%08h desc=%0d load=%0d beats=%0d errors=%0d",
               idx, v.lst, v.base, v.desc, v.ld, v.n, n_bad - bad0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{10'h013, 32'h2000_0000, 1'b0, 1'b0, 3,  32'h2000_0000, 4'd4,  32'h2000_000C};
      vecs[1] = '{10'h10F, 32'h2000_0100, 1'b1, 1'b0, 5,  32'h2000_00EC, 4'd14, 32'h2000_00EC};
      vecs[2] = '{10'h201, 32'h2000_0000, 1'b0, 1'b1, 2,  32'h2000_0000, 4'd15, 32'h2000_0008};
      vecs[3] = '{10'h3FF, 32'h1000_0000, 1'b1, 1'b1, 10, 32'h0FFF_FFD8, 4'd15, 32'h0FFF_FFD8};
      vecs[4] = '{10'h080, 32'h0000_0010, 1'b1, 1'b0, 1,  32'h0000_000C, 4'd7,  32'h0000_000C};

      #1 rst = 1'b0;
      #11;
      chk_all_zero("reset");
      $display("txn reset initial errors=%0d", n_bad);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 5; i++)
         run_vec(i, vecs[i]);

      // Second beat stalled 3 cycles; a start pulse during the stall must be ignored.
      @(negedge clk);
      reg_list = 10'h013; base_addr = 32'h0000_0040; descending = 1'b0;
      is_load = 1'b0; ack = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; reg_list = '0;
      #1 chk("stall_b0_addr", beat_addr, 32'h0000_0040);
      @(negedge clk);
      ack = 1'b0;
      for (int s = 0; s < 3; s++) begin
         start = (s == 1);
         reg_list = (s == 1) ? 10'h3FF : 10'h000;
         #1;
         chk("stall_reg",  32'(beat_reg),   32'd1);
         chk("stall_addr", beat_addr,       32'h0000_0044);
         chk("stall_list", 32'(list_left),  32'h012);
         chk("stall_vld",  32'(beat_valid), 32'd1);
         @(negedge clk);
      end
      start = 1'b0; reg_list = '0; ack = 1'b1;
      #1 chk("stall_acc_addr", beat_addr, 32'h0000_0044);
      @(negedge clk);
      #1;
      chk("stall_b2_reg",  32'(beat_reg),  32'd4);
      chk("stall_b2_addr", beat_addr,      32'h0000_0048);
      chk("stall_b2_list", 32'(list_left), 32'h010);
      @(negedge clk);
      #1 chk("stall_done", 32'(done), 32'd1);
      @(negedge clk);
      #1 chk("stall_idle", 32'(busy), 32'd0);
      @(negedge clk);
      #1 chk("stall_no_relaunch", 32'(beat_valid), 32'd0);
      ack = 1'b0;
      $display("txn stall errors_so_far=%0d", n_bad);

      // Empty list: no beats, done one cycle later, no writeback.
      @(negedge clk);
      reg_list = 10'h000; base_addr = 32'h1234_5678; ack = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("empty_done",  32'(done),       32'd1);
      chk("empty_busy",  32'(busy),       32'd0);
      chk("empty_beat",  32'(beat_valid), 32'd0);
      chk("empty_wbv",   32'(wb_valid),   32'd0);
      @(negedge clk);
      #1 chk("empty_done_clr", 32'(done), 32'd0);
      ack = 1'b0;
      $display("txn empty errors_so_far=%0d", n_bad);

      // Reset during the wrapped second beat, then a clean rerun.
      @(negedge clk);
      reg_list = 10'h003; base_addr = 32'hFFFF_FFFC; descending = 1'b0;
      is_load = 1'b0; ack = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; reg_list = '0;
      #1 chk("wrap_b0_addr", beat_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      ack = 1'b0;
      #1;
      chk("wrap_b1_addr", beat_addr,     32'h0000_0000);
      chk("wrap_b1_reg",  32'(beat_reg), 32'd1);
      #2 rst = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      $display("txn midreset errors_so_far=%0d", n_bad);
      run_vec(5, '{10'h003, 32'hFFFF_FFFC, 1'b0, 1'b0, 2, 32'hFFFF_FFFC, 4'd1, 32'h0000_0004});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Sequences Thumb multiple-register transfers (LDM/STM/PUSH/POP) decoded by the fetch stage. It captures the 10-bit register list and base address when the fetch stage raises its multiple-instruction pulse. It then issues one register/address beat per memory handshake, holds fetch stalled while busy, and optionally produces the final base-register writeback. It sits between stage_fetch and the load/store datapath and drives the `list` feedback into fetch.

## Interface
- No parameters; widths are fixed constants in the shared package.
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle multiple-instruction pulse from fetch; sampled only in IDLE.
- is_load  in  1  1 = LDM/POP, 0 = STM/PUSH; captured with start.
- descending  in  1  1 = PUSH (full-descending), 0 = ascending; captured with start.
- reg_list  in  10  bits 7:0 = R0–R7, bit 8 = R14 (LR), bit 9 = R15 (PC).
- base_addr  in  32  base register value; captured with start.
- ack  in  1  memory accepted the current beat.
- busy  out  1  transfer in progress; stalls fetch.
- list_left  out  10  registers not yet acknowledged; fed back to fetch as `list`.
- beat_valid  out  1  beat presented.
- beat_reg  out  4  register index of beat (0–7, 14, 15).
- beat_addr  out  32  word address of beat.
- beat_load  out  1  captured is_load.
- pc_load  out  1  one-cycle pulse when a load beat to R15 is acked.
- wb_valid  out  1  base writeback strobe (MULSEQ_WB_EN only).
- wb_data  out  32  new base value.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, XFER, WB.
- IDLE, start=1, list≠0:
  - capture list, is_load, descending.
  - n = popcount(list).
  - addr = descending ? base − 4n : base.
  - wb_data = descending ? base − 4n : base + 4n.
  - go to XFER.
- IDLE, start=1, list=0: no beats; done pulses next cycle, no writeback, stay IDLE.
- XFER:
  - beat_reg = lowest set bit of list_left (bit 8 → 14, bit 9 → 15).
  - beat_valid=1; beat_addr = current addr.
  - On ack: clear that bit; addr += 4.
  - pc_load pulses if beat_load and beat_reg=15.
  - If it was the last bit, go to WB.
- WB: wb_valid=1 for one cycle if MULSEQ_WB_EN; done=1; return to IDLE.
- Registers are always transferred in ascending index order at ascending addresses, for both directions.
- All address arithmetic is modulo 2^32; wrap-around is silent.
- start while busy is ignored; fetch must not pulse again until done.
- Reset, including mid-transfer: immediately IDLE. All outputs 0 except beat_reg=0 and list_left=0. No partial writeback.

## Timing
- start(cycle T) → busy=1, beat_valid=1 at T+1; first beat is combinationally valid from registered state.
- beat_valid held with stable beat_reg/addr until ack; ack may arrive in the same cycle beat_valid rises.
- ack at cycle C with bits remaining → next beat presented at C+1.
- ack on the last beat at C → WB at C+1 (wb_valid, done, busy=1) → IDLE at C+2 (busy=0).
- Minimum transfer of n registers with ack tied high: n+1 cycles busy.
- pc_load is asserted in the same cycle as the accepting ack.
- ack outside XFER is ignored.

## Configuration
- MULSEQ_WB_EN defined: WB state asserts wb_valid and wb_data carries the new base.
- MULSEQ_WB_EN undefined:
  - wb_valid and wb_data are tied 0 and the writeback adder is removed.
  - WB state still exists so done timing is identical.

## Structure
- Shared package mulseq_pkg holds:
  - LIST_W=10
  - REG_LR=4'd14, REG_PC=4'd15
  - state encoding IDLE/XFER/WB
  - WORD_BYTES=4
- One sub-module, list_lsb_enc: a combinational lowest-set-bit encoder over 10 bits. It outputs a 4-bit register index, a one-hot clear mask, and a `last` flag (exactly one bit set). The popcount stays inline.

## Test plan
- STM list=0x013 (R0,R1,R4), base=0x2000_0000, ascending, ack high → beats R0@0x2000_0000, R1@0x2000_0004, R4@0x2000_0008. wb_data=0x2000_000C; done at T+4.
- PUSH list=0x10F (R0–R3, LR), base=0x2000_0100, descending → addrs 0x2000_00EC…0x2000_00FC, last beat_reg=14, wb_data=0x2000_00EC.
- POP list=0x201 (R0, PC), base=0x2000_0000, is_load=1 → pc_load pulses exactly on the R15 ack; beat_addr=0x2000_0004.
- ack stalled 3 cycles on second beat → beat_reg/addr stable; list_left unchanged until ack; a start pulse during the stall is ignored.
- list=0x000 start → no beat_valid, done at T+1, wb_valid stays 0.
- rst low mid-XFER at ascending base=0xFFFF_FFFC wrapped beat → all outputs 0 asynchronously. A new start after release runs cleanly; a second run confirms the wrap to 0x0000_0000.
